conv2d_frame_sequencer: RTL and testbench

//  Frame-level controller for one Conv2d datapath instance. It loads a frame word-serially

---
 rtl/conv2d_frame_sequencer.sv | 142 ++++++++++++++
 tb/tb_conv2d_frame_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_frame_sequencer
// Description : Loads a frame word-serially into the Conv2d input bus, strobes
//               clken after a settle delay, then streams the result out.
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_frame_sequencer #(
    parameter int BITWIDTH     = 8,
    parameter int DATAWORDS    = 2352,
    parameter int RESULTWORDS  = 576,
    parameter int SETTLECYCLES = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [BITWIDTH-1:0]                 in_data,
    output logic [BITWIDTH*DATAWORDS-1:0]       conv_data,
    output logic                                conv_clken,
    input  logic [2*BITWIDTH*RESULTWORDS-1:0]   conv_result,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [2*BITWIDTH-1:0]               out_data,
    output logic                                out_last,
    output logic                                busy,
    output logic                                frame_done
);

    localparam int c_WCNT_W = (DATAWORDS > 1)    ? $clog2(DATAWORDS)    : 1;
    localparam int c_SCNT_W = (SETTLECYCLES > 1) ? $clog2(SETTLECYCLES) : 1;
    localparam int c_RCNT_W = (RESULTWORDS > 1)  ? $clog2(RESULTWORDS)  : 1;

    localparam logic [c_WCNT_W-1:0] c_WORD_LAST   = c_WCNT_W'(DATAWORDS - 1);
    localparam logic [c_SCNT_W-1:0] c_SETTLE_LAST =
        c_SCNT_W'((SETTLECYCLES > 0) ? SETTLECYCLES - 1 : 0);
    localparam logic [c_RCNT_W-1:0] c_RES_LAST    = c_RCNT_W'(RESULTWORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [c_WCNT_W-1:0]   r_wordCnt;
    logic [c_SCNT_W-1:0]   r_settleCnt;
    logic [c_RCNT_W-1:0]   r_resCnt;
    logic                  r_frameDone;

    logic w_inXfer;
    logic w_outXfer;
    logic w_lastWord;
    logic w_lastRes;

    assign w_inXfer   = (r_state == S_LOAD) && in_valid;
    assign w_outXfer  = (r_state == S_DRAIN) && out_ready;
    assign w_lastWord = w_inXfer && (r_wordCnt == c_WORD_LAST);
    assign w_lastRes  = w_outXfer && (r_resCnt == c_RES_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:    w_nextState = S_LOAD;
            S_LOAD: begin
                if (w_lastWord) begin
                    w_nextState = (SETTLECYCLES == 0) ? S_CAPTURE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_settleCnt == c_SETTLE_LAST) begin
                    w_nextState = S_CAPTURE;
                end
            end
            S_CAPTURE: w_nextState = S_DRAIN;
            S_DRAIN: begin
                if (w_lastRes) begin
                    w_nextState = S_LOAD;
                end
            end
            default:   w_nextState = S_IDLE;
        endcase
    end

    // Counters wrap to zero on their final step so none ever exceeds its bound.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wordCnt   <= '0;
            r_settleCnt <= '0;
            r_resCnt    <= '0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= w_lastRes;
            if (w_inXfer) begin
                r_wordCnt <= w_lastWord ? '0 : r_wordCnt + 1'b1;
            end
            if (w_lastWord) begin
                r_settleCnt <= '0;
            end else if (r_state == S_SETTLE) begin
                r_settleCnt <= (r_settleCnt == c_SETTLE_LAST) ? '0 : r_settleCnt + 1'b1;
            end
            if (r_state == S_CAPTURE) begin
                r_resCnt <= '0;
            end else if (w_outXfer) begin
                r_resCnt <= w_lastRes ? '0 : r_resCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_data <= '0;
        end else if (w_inXfer) begin
            conv_data[int'(r_wordCnt)*BITWIDTH +: BITWIDTH] <= in_data;
        end
    end

    // Result words come straight from the Conv2d result register, which is
    // itself only updated at the capture edge, so out_data is stable in DRAIN.
    assign in_ready   = (r_state == S_LOAD);
    assign conv_clken = (r_state == S_CAPTURE);
    assign out_valid  = (r_state == S_DRAIN);
    assign busy       = (r_state == S_SETTLE) || (r_state == S_CAPTURE) || (r_state == S_DRAIN);
    assign out_last   = (r_state == S_DRAIN) && (r_resCnt == c_RES_LAST);
    assign out_data   = (r_state == S_DRAIN)
                      ? conv_result[int'(r_resCnt)*(2*BITWIDTH) +: 2*BITWIDTH]
                      : '0;
    assign frame_done = r_frameDone;

endmodule
`default_nettype wire

// File: tb/tb_conv2d_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2d_frame_sequencer
// Description : Scoreboard bench for conv2d_frame_sequencer, two instances
//               (settle delay 2 and 0) with a register model of Conv2d.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_frame_sequencer;

    localparam int BW = 8;
    localparam int DW = 9;
    localparam int RW = 4;
    localparam int SET[2] = '{2, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n      [2];
    logic                 in_valid   [2];
    logic                 in_ready   [2];
    logic [BW-1:0]        in_data    [2];
    logic [BW*DW-1:0]     conv_data  [2];
    logic                 conv_clken [2];
    logic [2*BW*RW-1:0]   convRes    [2];
    logic [2*BW*RW-1:0]   pendRes    [2];
    logic                 out_valid  [2];
    logic                 out_ready  [2];
    logic [2*BW-1:0]      out_data   [2];
    logic                 out_last   [2];
    logic                 busy       [2];
    logic                 frame_done [2];

    conv2d_frame_sequencer #(.BITWIDTH(BW), .DATAWORDS(DW), .RESULTWORDS(RW), .SETTLECYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .conv_data(conv_data[0]), .conv_clken(conv_clken[0]),
        .conv_result(convRes[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_last(out_last[0]), .busy(busy[0]), .frame_done(frame_done[0])
    );

    conv2d_frame_sequencer #(.BITWIDTH(BW), .DATAWORDS(DW), .RESULTWORDS(RW), .SETTLECYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .conv_data(conv_data[1]), .conv_clken(conv_clken[1]),
        .conv_result(convRes[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_last(out_last[1]), .busy(busy[1]), .frame_done(frame_done[1])
    );

    // Conv2d result register: captures the frame's result on the clken edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k])          convRes[k] <= '0;
            else if (conv_clken[k]) convRes[k] <= pendRes[k];
        end
    end

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [BW*DW-1:0] frameQ [2][$];
    logic [2*BW:0]    outQ   [2][$];

    int               expClken [2];
    int               expValid [2];
    int               expDone  [2];
    int               mWords   [2];
    logic             prevValid[2];
    logic             prevStall[2];
    logic             prevLast [2];
    logic [2*BW-1:0]  prevData [2];
    logic [BW*DW-1:0] snap     [2];

    task automatic check(int k, string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL inst%0d %s: actual=%0h required=%0h cycle=%0d", k, name, act, exp, cyc);
    endtask

    // Monitor: timing expectations from accepted-word counts, data from queues.
    always @(negedge clk) begin
        logic [BW*DW-1:0] f;
        logic [2*BW:0]    e;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) begin
                check(k, "reset_ctl", {in_ready[k], out_valid[k], conv_clken[k], busy[k],
                                       frame_done[k], out_last[k]}, '0);
                check(k, "reset_bus", {conv_data[k], out_data[k]}, '0);
                frameQ[k].delete();
                outQ[k].delete();
                expClken[k]  = -1;
                expValid[k]  = -1;
                expDone[k]   = -1;
                mWords[k]    = 0;
                prevValid[k] = 1'b0;
                prevStall[k] = 1'b0;
            end else begin
                if (in_valid[k] && in_ready[k]) begin
                    check(k, "busy_load", busy[k], 0);
                    if (mWords[k] == DW - 1) begin
                        mWords[k]   = 0;
                        expClken[k] = cyc + 1 + SET[k];
                    end else begin
                        mWords[k]++;
                    end
                end
                if (conv_clken[k] || cyc == expClken[k]) begin
                    check(k, "clken", conv_clken[k], cyc == expClken[k]);
                    if (cyc == expClken[k]) begin
                        check(k, "frame_avail", frameQ[k].size() != 0, 1);
                        if (frameQ[k].size() != 0) begin
                            f = frameQ[k].pop_front();
                            snap[k] = f;
                            check(k, "conv_data", conv_data[k], f);
                        end
                        check(k, "busy_capture", busy[k], 1);
                        expValid[k] = cyc + 1;
                        expClken[k] = -1;
                    end
                end
                if (out_valid[k] && !prevValid[k]) check(k, "valid_rise", cyc, expValid[k]);
                if (prevStall[k])
                    check(k, "hold", {out_valid[k], out_last[k], out_data[k]},
                          {1'b1, prevLast[k], prevData[k]});
                if (!out_valid[k]) check(k, "idle_out", {out_last[k], out_data[k]}, '0);
                if (out_valid[k] && out_ready[k]) begin
                    check(k, "busy_drain", busy[k], 1);
                    check(k, "data_stable", conv_data[k], snap[k]);
                    check(k, "result_avail", outQ[k].size() != 0, 1);
                    if (outQ[k].size() != 0) begin
                        e = outQ[k].pop_front();
                        check(k, "out_data", out_data[k], e[2*BW-1:0]);
                        check(k, "out_last", out_last[k], e[2*BW]);
                        if (e[2*BW]) expDone[k] = cyc + 1;
                    end
                end
                if (frame_done[k] || cyc == expDone[k]) begin
                    check(k, "frame_done", frame_done[k], cyc == expDone[k]);
                    if (cyc == expDone[k]) expDone[k] = -1;
                end
                prevValid[k] = out_valid[k];
                prevStall[k] = out_valid[k] && !out_ready[k];
                prevLast[k]  = out_last[k];
                prevData[k]  = out_data[k];
            end
        end
    end

    task automatic send_word(int k, logic [BW-1:0] d);
        bit got = 1'b0;
        in_data[k]  = d;
        in_valid[k] = 1'b1;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = in_ready[k];
            @(posedge clk);
            #1;
        end
        in_valid[k] = 1'b0;
        check(k, "in_accept", got, 1);
    endtask

    // Reference: the frame bus is the words in order, results are the chosen words.
    task automatic load_frame(int k, int base, int gapMode, bit fixedRes);
        logic [BW*DW-1:0]   f;
        logic [2*BW*RW-1:0] r;
        int                 g;
        for (int i = 0; i < DW; i++)
            f[i*BW +: BW] = (base != 0) ? BW'(base + i) : BW'($urandom);
        r = fixedRes ? {16'd4, 16'd3, 16'd2, 16'd1} : {$urandom, $urandom};
        pendRes[k] = r;
        frameQ[k].push_back(f);
        for (int i = 0; i < RW; i++) outQ[k].push_back({i == RW - 1, r[i*2*BW +: 2*BW]});
        for (int i = 0; i < DW; i++) begin
            send_word(k, f[i*BW +: BW]);
            g = (gapMode == 0) ? 0 : (gapMode == 1) ? 2 : $urandom_range(0, 2);
            if (i < DW - 1) repeat (g) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain(int k, int mode, bit junk, int stopAfter);
        logic [6:0] pat = 7'b1001011;
        int idx = 0;
        int n = 0;
        bit done = 1'b0;
        bit stopped = 1'b0;
        bit lastX;
        if (junk) begin in_valid[k] = 1'b1; in_data[k] = BW'($urandom); end
        out_ready[k] = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 0);
        for (int t = 0; t < 300 && !done && !stopped; t++) begin
            @(negedge clk);
            if (frame_done[k]) begin
                done = 1'b1;
            end else begin
                lastX = out_valid[k] && out_ready[k] && out_last[k];
                if (out_valid[k] && out_ready[k]) n++;
                @(posedge clk);
                #1;
                if (lastX) in_valid[k] = 1'b0;
                else if (junk) begin in_valid[k] = 1'b1; in_data[k] = BW'($urandom); end
                case (mode)
                    0: out_ready[k] = 1'b1;
                    1: begin
                        if (out_valid[k]) begin
                            out_ready[k] = (idx < 7) ? pat[6-idx] : 1'b1;
                            idx++;
                        end else begin
                            out_ready[k] = 1'b0;
                        end
                    end
                    default: out_ready[k] = 1'($urandom_range(0, 1));
                endcase
                if (stopAfter >= 0 && n >= stopAfter) stopped = 1'b1;
            end
        end
        if (stopAfter < 0) begin
            check(k, "drain_done", done, 1);
            check(k, "ready_after_done", in_ready[k], 1);
            @(posedge clk);
            #1;
        end
        out_ready[k] = 1'b0;
        in_valid[k]  = 1'b0;
    endtask

    task automatic run_suite(int k);
        load_frame(k, 1, 0, 1'b1);
        check(k, "ready_after_last", in_ready[k], 0);
        drain(k, 0, 1'b0, -1);
        load_frame(k, 0, 0, 1'b0);
        drain(k, 1, 1'b0, -1);
        load_frame(k, 0, 1, 1'b0);
        drain(k, 2, 1'b1, -1);
        for (int i = 0; i < 6; i++) begin
            load_frame(k, 0, 2, 1'b0);
            drain(k, 2, 1'($urandom_range(0, 1)), -1);
        end
        load_frame(k, 0, 2, 1'b0);
        drain(k, 0, 1'b0, 2);
        rst_n[k] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n[k] = 1'b1;
        load_frame(k, 10, 0, 1'b0);
        drain(k, 0, 1'b0, -1);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k]     = 1'b0;
            in_valid[k]  = 1'b1;
            in_data[k]   = 8'hA5;
            out_ready[k] = 1'b0;
            pendRes[k]   = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0;
            rst_n[k]    = 1'b1;
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) check(k, "idle_ready", in_ready[k], 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check(k, "load_ready", in_ready[k], 1);
        for (int k = 0; k < 2; k++) run_suite(k);
        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check(k, "frameq_empty", frameQ[k].size(), 0);
            check(k, "outq_empty", outQ[k].size(), 0);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
